// File: rtl/sys_ctrl_pkg.sv
// Opcodes, FSM state encoding and ALU operand addresses shared by the UART
// command controller and its bench.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR       = 8'hAA;
    localparam logic [7:0] CMD_RD       = 8'hBB;
    localparam logic [7:0] CMD_ALU      = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
    localparam logic [7:0] CMD_BURST_WR = 8'hEE;

    localparam int ADDR_OP_A = 0;
    localparam int ADDR_OP_B = 1;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_F,
        ALU_WAIT, BW_ADDR, BW_CNT, BW_DATA, TX_SEND
    } state_t;

    // States that are waiting for the next byte of a frame; only these are timed.
    function automatic logic is_collecting(input state_t s);
        return s inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_F,
                         BW_ADDR, BW_CNT, BW_DATA};
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_serializer.sv
// Sends one or two bytes of a result word, low byte first, through the UART TX
// handshake: at most one pulse every other cycle and never while TX is busy.
module sys_ctrl_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [2*DATA_WIDTH-1:0] load_data,
    input  logic [1:0]              load_count,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    tx_d_vld,
    output logic                    pending
);

    logic [2*DATA_WIDTH-1:0] data_q, data_d, cur_data;
    logic [1:0]              rem_q, rem_d, cur_rem;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    fire;

    // A load can fire in its own cycle so the first byte leaves one edge after the result strobe.
    always_comb begin
        cur_data  = load ? load_data : data_q;
        cur_rem   = load ? load_count : rem_q;
        fire      = (cur_rem != 2'd0) && !tx_busy && !tx_vld_q;
        data_d    = cur_data;
        rem_d     = cur_rem;
        tx_vld_d  = fire;
        tx_data_d = tx_data_q;
        if (fire) begin
            tx_data_d = cur_data[DATA_WIDTH-1:0];
            data_d    = cur_data >> DATA_WIDTH;
            rem_d     = cur_rem - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            rem_q     <= 2'd0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            data_q    <= data_d;
            rem_q     <= rem_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    assign tx_p_data = tx_data_q;
    assign tx_d_vld  = tx_vld_q;
    assign pending   = (rem_q != 2'd0);

endmodule

// File: rtl/sys_cmd_ctrl_burst.sv
// UART command controller: turns RX byte frames into register-file writes/reads,
// ALU operations and burst writes, and returns results through the TX serializer.
//
// state    | meaning
// IDLE     | waiting for an opcode
// WR_ADDR  | write: waiting for address byte
// WR_DATA  | write: waiting for data byte
// RD_ADDR  | read: waiting for address byte
// RD_WAIT  | read: waiting for RdData_Valid
// ALU_A    | ALU: waiting for operand A (written to addr 0)
// ALU_B    | ALU: waiting for operand B (written to addr 1)
// ALU_F    | ALU: waiting for function byte
// ALU_WAIT | ALU: waiting for OUT_VALID
// BW_ADDR  | burst: waiting for start address
// BW_CNT   | burst: waiting for byte count
// BW_DATA  | burst: collecting data bytes
// TX_SEND  | result bytes draining through the serializer
module sys_cmd_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [DATA_WIDTH-1:0]   WrData,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_BUSY,
    output logic                    CMD_ERR
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d, addr_q, addr_d, rx_addr;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d, cnt_q, cnt_d;
    logic [FUN_WIDTH-1:0]    alu_fun_q, alu_fun_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
    logic                    gate_q, gate_d, cmd_err_q, cmd_err_d;
    logic                    collecting, timeout;
    logic                    ser_load, ser_pending;
    logic [2*DATA_WIDTH-1:0] ser_data;
    logic [1:0]              ser_count;
    logic [7:0]              opcode;

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        cnt_d      = cnt_q;
        alu_fun_d  = alu_fun_q;
        gate_d     = gate_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        alu_en_d   = 1'b0;
        cmd_err_d  = 1'b0;
        ser_load   = 1'b0;
        ser_data   = '0;
        ser_count  = 2'd0;
        opcode     = RX_P_DATA[7:0];
        rx_addr    = RX_P_DATA[ADDR_WIDTH-1:0];
        collecting = is_collecting(state_q);
        timeout    = collecting && !RX_D_VLD && (tmo_q == '0);

        // Down-counter reloads on every byte and whenever no frame is being collected.
        if (RX_D_VLD || !collecting)
            tmo_d = TMO_LOAD;
        else if (tmo_q != '0)
            tmo_d = tmo_q - TMO_W'(1);
        else
            tmo_d = tmo_q;

        case (state_q)
            IDLE: if (RX_D_VLD) begin
                case (opcode)
                    CMD_WR:       state_d = WR_ADDR;
                    CMD_RD:       state_d = RD_ADDR;
                    CMD_BURST_WR: state_d = BW_ADDR;
                    CMD_ALU:      begin state_d = ALU_A; gate_d = 1'b1; end
                    CMD_ALU_NOP:  begin state_d = ALU_F; gate_d = 1'b1; end
                    default:      cmd_err_d = 1'b1;
                endcase
            end
            WR_ADDR: if (RX_D_VLD) begin
                addr_d  = rx_addr;
                state_d = WR_DATA;
            end
            WR_DATA: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                address_d = addr_q;
                wr_data_d = RX_P_DATA;
                state_d   = IDLE;
            end
            RD_ADDR: if (RX_D_VLD) begin
                rd_en_d   = 1'b1;
                address_d = rx_addr;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                cmd_err_d = RX_D_VLD;
                if (RdData_Valid) begin
                    ser_load  = 1'b1;
                    ser_data  = {{DATA_WIDTH{1'b0}}, RdData};
                    ser_count = 2'd1;
                    state_d   = TX_SEND;
                end
            end
            ALU_A, ALU_B: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                wr_data_d = RX_P_DATA;
                address_d = (state_q == ALU_A) ? ADDR_WIDTH'(ADDR_OP_A) : ADDR_WIDTH'(ADDR_OP_B);
                state_d   = (state_q == ALU_A) ? ALU_B : ALU_F;
            end
            ALU_F: if (RX_D_VLD) begin
                alu_en_d  = 1'b1;
                alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                state_d   = ALU_WAIT;
            end
            ALU_WAIT: begin
                cmd_err_d = RX_D_VLD;
                if (OUT_VALID) begin
                    ser_load  = 1'b1;
                    ser_data  = ALU_OUT;
                    ser_count = 2'd2;
                    gate_d    = 1'b0;
                    state_d   = TX_SEND;
                end
            end
            BW_ADDR: if (RX_D_VLD) begin
                addr_d  = rx_addr;
                state_d = BW_CNT;
            end
            BW_CNT: if (RX_D_VLD) begin
                cnt_d   = RX_P_DATA;
                state_d = (RX_P_DATA == '0) ? IDLE : BW_DATA;
            end
            BW_DATA: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                address_d = addr_q;
                wr_data_d = RX_P_DATA;
                addr_d    = addr_q + ADDR_WIDTH'(1);
                cnt_d     = cnt_q - DATA_WIDTH'(1);
                if (cnt_q == DATA_WIDTH'(1))
                    state_d = IDLE;
            end
            TX_SEND: begin
                cmd_err_d = RX_D_VLD;
                if (!ser_pending)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d   = IDLE;
            cmd_err_d = 1'b1;
            gate_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            address_q <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
            alu_fun_q <= '0;
            tmo_q     <= TMO_LOAD;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            gate_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
            alu_fun_q <= alu_fun_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            gate_q    <= gate_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    sys_ctrl_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
        .clk        (CLK),
        .rst        (RST),
        .load       (ser_load),
        .load_data  (ser_data),
        .load_count (ser_count),
        .tx_busy    (TX_BUSY),
        .tx_p_data  (TX_P_DATA),
        .tx_d_vld   (TX_D_VLD),
        .pending    (ser_pending)
    );

    assign Address     = address_q;
    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign WrData      = wr_data_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = gate_q;
    assign CMD_ERR     = cmd_err_q;

endmodule
